// File: rtl/alu_share_arbiter.sv
// Shared 32-bit ALU controller: round-robin arbitration among NUM_REQ cores,
// single-cycle ALU ops, and a 32-step shift-add multiply built on the ALU's ADD.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_op,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [5*NUM_REQ-1:0]   req_shamt,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_result,
  output logic                   busy,
  output logic [3:0]             alu_ctl,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [4:0]             alu_shamt,
  input  logic [31:0]            alu_result
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_MAX = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, g_q, g_d;
  logic [3:0]     op_q, op_d;
  logic [31:0]    a_q, a_d, b_q, b_d, result_q, result_d;
  logic [4:0]     shamt_q, shamt_d, cnt_q, cnt_d;

  logic           found;
  logic [IDW-1:0] sel;
  logic [IDW:0]   cand;
  logic [3:0]     sel_op;
  logic [31:0]    sel_a, sel_b;
  logic [4:0]     sel_shamt;

  // First asserted request searching upward from ptr_q, with wrap-around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_shamt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDW'(i)) begin
        sel_op    = req_op[4*i +: 4];
        sel_a     = req_a[32*i +: 32];
        sel_b     = req_b[32*i +: 32];
        sel_shamt = req_shamt[5*i +: 5];
      end
    end
  end

  // In MUL, result_q is the accumulator, a_q the shifted multiplicand and b_q the multiplier.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    g_d        = g_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    shamt_d    = shamt_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_result = '0;
    alu_ctl    = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_shamt  = '0;
    case (state_q)
      S_IDLE: begin
        if (found && !rst) begin
          req_ready[sel] = 1'b1;
          g_d     = sel;
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          shamt_d = sel_shamt;
          if (sel_op == OP_MUL) begin
            result_d = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            state_d  = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        alu_ctl   = (op_q <= OP_MAX) ? op_q : 4'd0;
        alu_a     = a_q;
        alu_b     = b_q;
        alu_shamt = shamt_q;
        result_d  = (op_q <= OP_MAX) ? alu_result : 32'h0;
        state_d   = S_RESP;
      end
      S_MUL: begin
        alu_ctl  = OP_ADD;
        alu_a    = result_q;
        alu_b    = b_q[0] ? a_q : 32'h0;
        result_d = alu_result;
        a_d      = a_q << 1;
        b_d      = b_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid[g_q] = 1'b1;
        rsp_result     = result_q;
        ptr_d          = (g_q == IDW'(NUM_REQ-1)) ? '0 : g_q + IDW'(1);
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      g_q      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      shamt_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      g_q      <= g_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shamt_q  <= shamt_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a combinational ALU model on the ALU port, a
// transaction-level reference model checked every cycle, directed and random traffic.
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [4*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a, req_b;
  logic [5*NUM_REQ-1:0]  req_shamt;
  logic [NUM_REQ-1:0]    req_ready, rsp_valid;
  logic [31:0]           rsp_result;
  logic                  busy;
  logic [3:0]            alu_ctl;
  logic [31:0]           alu_a, alu_b, alu_result;
  logic [4:0]            alu_shamt;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_shamt(req_shamt), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .busy(busy), .alu_ctl(alu_ctl), .alu_a(alu_a),
    .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_result(alu_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Plain ALU behaviour: shifts act on operand b; MUL and illegal codes give 0.
  function automatic logic [31:0] aluFn(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a ^ b;
      4'd4: return b << sh;
      4'd5: return b >> sh;
      4'd6: return a - b;
      4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] refResult(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    if (op == 4'd8) return a * b;
    return aluFn(op, a, b, sh);
  endfunction

  assign alu_result = aluFn(alu_ctl, alu_a, alu_b, alu_shamt);

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: one in-flight transaction, a round-robin pointer, and the cycle its response is due.
  bit          mBusy = 1'b0;
  int          mPtr  = 0;
  int          mG    = 0;
  int          mResp = 0;
  int          mC;
  logic [31:0] mRes  = '0;
  logic [NUM_REQ-1:0] expReady, expRsp;

  always @(negedge clk) begin
    checkOutput("no_x", 32'($isunknown({req_ready, rsp_valid, rsp_result, busy, alu_ctl, alu_a, alu_b, alu_shamt})), 32'd0);
    if (rst) begin
      mBusy = 1'b0;
      mPtr  = 0;
      checkOutput("rst_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_rsp_result", rsp_result, 32'd0);
      checkOutput("rst_alu_zero", alu_a | alu_b | 32'(alu_ctl) | 32'(alu_shamt), 32'd0);
    end else begin
      expReady = '0;
      expRsp   = '0;
      if (!mBusy) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          mC = (mPtr + k) % NUM_REQ;
          if (req_valid[mC] && expReady == '0) expReady[mC] = 1'b1;
        end
      end
      if (mBusy && cyc == mResp) expRsp[mG] = 1'b1;
      checkOutput("ready", 32'(req_ready), 32'(expReady));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(expRsp));
      checkOutput("busy", 32'(busy), 32'(mBusy));
      if (expRsp != '0) checkOutput("rsp_result", rsp_result, mRes);
      if (!mBusy) checkOutput("alu_idle_zero", alu_a | alu_b | 32'(alu_ctl) | 32'(alu_shamt), 32'd0);
      if (expRsp != '0) begin
        mBusy = 1'b0;
        mPtr  = (mG + 1) % NUM_REQ;
      end else if (expReady != '0) begin
        for (int k = 0; k < NUM_REQ; k++) if (expReady[k]) mG = k;
        mRes  = refResult(req_op[4*mG +: 4], req_a[32*mG +: 32], req_b[32*mG +: 32], req_shamt[5*mG +: 5]);
        mResp = cyc + ((req_op[4*mG +: 4] == 4'd8) ? 33 : 2);
        mBusy = 1'b1;
      end
    end
  end

  task automatic applyStimulus(int i, logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] sh);
    req_valid[i]          = 1'b1;
    req_op[4*i +: 4]      = op;
    req_a[32*i +: 32]     = a;
    req_b[32*i +: 32]     = b;
    req_shamt[5*i +: 5]   = sh;
  endtask

  task automatic dropReq(int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Returns just after the accept edge.
  task automatic waitAccept(int i, output int t);
    bit got = 1'b0;
    t = cyc;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) begin got = 1'b1; t = cyc; end
    end
    if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic waitAnyAccept(output int idx, output int t);
    bit got = 1'b0;
    idx = -1;
    t   = cyc;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      for (int k = 0; k < NUM_REQ; k++)
        if (!got && req_valid[k] && req_ready[k]) begin got = 1'b1; idx = k; t = cyc; end
    end
    if (!got) checkOutput("any_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Returns at the negedge of the response cycle.
  task automatic waitResponse(string name, int i, int t, int lat, logic [31:0] exp);
    bit got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid != '0) got = 1'b1;
    end
    if (!got) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    else begin
      checkOutput({name, "_who"}, 32'(rsp_valid), 32'd1 << i);
      checkOutput({name, "_latency"}, 32'(cyc - t), 32'(lat));
      checkOutput({name, "_value"}, rsp_result, exp);
    end
  endtask

  task automatic randomReq(int i);
    logic [31:0] b;
    b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    applyStimulus(i, 4'($urandom_range(0, 15)), $urandom, b, 5'($urandom_range(0, 31)));
  endtask

  int t, t0, t1, idx, prevT, rspSeen;
  logic [NUM_REQ-1:0] accMask;

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; req_shamt = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;

    // Single ADD: ready in the same cycle, response two cycles later.
    t0 = cyc;
    applyStimulus(0, 4'd2, 32'd5, 32'd7, 5'd0);
    waitAccept(0, t);
    checkOutput("add_same_cycle_ready", 32'(t), 32'(t0));
    dropReq(0);
    waitResponse("add", 0, t, 2, 32'd12);

    // All four cores held: grant order 0,1,2,3,0 every 3 cycles.
    @(posedge clk); #1;
    resetPulse();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 4'd6, 32'd10, 32'(i), 5'd0);
    prevT = 0;
    for (int k = 0; k < 5; k++) begin
      waitAnyAccept(idx, t);
      checkOutput("rr_grant", 32'(idx), 32'(k % 4));
      if (k > 0) checkOutput("rr_gap", 32'(t - prevT), 32'd3);
      prevT = t;
      waitResponse("rr_sub", k % 4, t, 2, 32'(10 - (k % 4)));
    end
    @(posedge clk); #1;
    req_valid = '0;

    // Multiplies.
    applyStimulus(0, 4'd8, 32'hFFFFFFFD, 32'd7, 5'd0);
    waitAccept(0, t); dropReq(0);
    waitResponse("mul_neg", 0, t, 33, 32'hFFFFFFEB);
    @(posedge clk); #1;
    applyStimulus(0, 4'd8, 32'h10000, 32'h10000, 5'd3);
    waitAccept(0, t); dropReq(0);
    waitResponse("mul_ovf", 0, t, 33, 32'h0);
    @(posedge clk); #1;
    applyStimulus(0, 4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
    waitAccept(0, t); dropReq(0);
    waitResponse("mul_ones", 0, t, 33, 32'h1);

    // Edge ops on core 1 (leaves the pointer at 2).
    @(posedge clk); #1;
    applyStimulus(1, 4'd4, 32'h1234, 32'd1, 5'd31);
    waitAccept(1, t); dropReq(1);
    waitResponse("sll", 1, t, 2, 32'h80000000);
    @(posedge clk); #1;
    applyStimulus(1, 4'd7, 32'hFFFFFFFF, 32'd1, 5'd0);
    waitAccept(1, t); dropReq(1);
    waitResponse("slt", 1, t, 2, 32'd1);
    @(posedge clk); #1;
    applyStimulus(1, 4'd12, 32'd5, 32'd6, 5'd2);
    waitAccept(1, t); dropReq(1);
    waitResponse("illegal", 1, t, 2, 32'd0);

    // Reset in the 10th MUL cycle aborts the op and returns the pointer to 0.
    @(posedge clk); #1;
    applyStimulus(3, 4'd8, 32'd123, 32'd456, 5'd0);
    waitAccept(3, t); dropReq(3);
    repeat (9) @(posedge clk);
    #1;
    resetPulse();
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    rspSeen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsp_valid != '0) rspSeen++;
    end
    checkOutput("abort_no_rsp", 32'(rspSeen), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1, 4'd2, 32'd1, 32'd2, 5'd0);
    applyStimulus(3, 4'd2, 32'd3, 32'd4, 5'd0);
    waitAnyAccept(idx, t);
    checkOutput("post_reset_grant", 32'(idx), 32'd1);
    if (idx >= 0) dropReq(idx);
    waitResponse("post_reset_c1", 1, t, 2, 32'd3);
    waitAccept(3, t); dropReq(3);
    waitResponse("post_reset_c3", 3, t, 2, 32'd7);

    // Core 2 holds its request through RESP and is re-granted after one IDLE cycle.
    @(posedge clk); #1;
    applyStimulus(2, 4'd2, 32'd100, 32'd23, 5'd0);
    waitAccept(2, t1);
    waitResponse("b2b_first", 2, t1, 2, 32'd123);
    checkOutput("b2b_resp_busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("b2b_idle_busy", 32'(busy), 32'd0);
    checkOutput("b2b_regrant", 32'(req_ready[2]), 32'd1);
    @(posedge clk); #1;
    dropReq(2);
    @(negedge clk);
    checkOutput("b2b_exec_busy", 32'(busy), 32'd1);
    waitResponse("b2b_second", 2, t1 + 3, 2, 32'd123);

    // Random traffic with withdrawals and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      accMask = req_valid & req_ready;
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i]) begin
          if (accMask[i]) begin
            if ($urandom_range(0, 1) == 1) randomReq(i);
            else dropReq(i);
          end else if ($urandom_range(0, 29) == 0) dropReq(i);
        end else if ($urandom_range(0, 3) == 0) randomReq(i);
      end
    end
    rst = 1'b0;
    req_valid = '0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
